// File: rtl/if_id_queue.sv
// if_id_queue
// -----------------------------------------------------------------------------
// Instruction queue between fetch and decode. Buffers up to DEPTH fetched
// {pc, inst} pairs in a circular buffer so fetch can run ahead while decode
// stalls. A one-cycle flush (branch/jump redirect) discards every entry.
// When the queue presents nothing, out_pc/out_inst are driven to zero.
//
// Optional feature: define IF_ID_QUEUE_BYPASS_EN to forward in_* straight to
// out_* while the queue is empty and not flushing (zero-cycle latency).
//
// Parameters:
//   ADDR_W  PC width
//   INST_W  instruction width
//   DEPTH   number of entries, power of two, >= 2
//   CNT_W   occupancy counter width
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   flush      discard all entries at the next edge (beats push and pop)
//   in_valid   fetch offers {in_pc, in_inst}
//   in_ready   queue accepts the offered pair
//   in_pc      offered PC
//   in_inst    offered instruction
//   out_valid  head entry valid for decode
//   out_ready  decode consumes the head
//   out_pc     head PC, 0 when out_valid=0
//   out_inst   head instruction, 0 when out_valid=0
//   count      current occupancy, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid never waits on ready; in_ready is a function of local
// state and flush only, so there is no combinational path from out_ready to
// in_ready. Once the queue raises out_valid it holds the same head until it
// is consumed or a flush/reset discards it.
// -----------------------------------------------------------------------------
module if_id_queue #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [INST_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];
   logic [PTR_W-1:0]  wp;
   logic [PTR_W-1:0]  rp;

   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              wr_en;
   logic              rd_en;
   logic              byp_active;
   logic              byp_take;
   logic [ADDR_W-1:0] sel_pc;
   logic [INST_W-1:0] sel_inst;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign in_ready = ~full & ~flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
   // Empty and not flushing: the offered pair is the head.
   assign byp_active = empty & ~flush;
`else
   assign byp_active = 1'b0;
`endif

   always_comb begin
      sel_pc    = mem_pc[rp];
      sel_inst  = mem_inst[rp];
      out_valid = ~empty;
      if (byp_active) begin
         sel_pc    = in_pc;
         sel_inst  = in_inst;
         out_valid = in_valid;
      end
   end

   // Bubble outputs are all-zero so decode sees a clean NOP-free slot.
   assign out_pc   = out_valid ? sel_pc   : '0;
   assign out_inst = out_valid ? sel_inst : '0;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // A pair forwarded and consumed in the same cycle never touches storage.
   assign byp_take = byp_active & in_valid & out_ready;
   assign wr_en    = push & ~byp_take;
   assign rd_en    = pop  & ~byp_take;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr_en) wp <= wp + PTR_W'(1);
         if (rd_en) rp <= rp + PTR_W'(1);
         if (wr_en && !rd_en)
            count <= count + CNT_W'(1);
         else if (rd_en && !wr_en)
            count <= count - CNT_W'(1);
      end
   end

   // Storage is never cleared; pointers alone define what is live.
   always_ff @(posedge clk) begin
      if (wr_en && !rst && !flush) begin
         mem_pc[wp]   <= in_pc;
         mem_inst[wp] <= in_inst;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4, 32-bit PC and instruction).
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked 1 more unit later, well away from the next edge.
module tb_if_id_queue;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_pc;
   logic [INST_W-1:0] in_inst;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_pc;
   logic [INST_W-1:0] out_inst;
   logic [CNT_W-1:0]  count;

   int tests_run;
   int tests_failed;

   if_id_queue #(
      .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_inst(out_inst), .count(count)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge, then step just past it
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      cycle(); cycle();
      rst = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
      tests_run++; if (out_inst !== 32'h0) begin tests_failed++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      cycle();
      tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_state: count %0d out_valid %b want 0 0", count, out_valid); end
   endtask

   task automatic test_fill_drain();
      logic [31:0] exp_pc;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_pc = 32'(4 * k); in_inst = 32'h13 + 32'(k);
         #1;
         tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_in_ready_%0d: got %b want 1", k, in_ready); end
         cycle();
      end
      tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL fill_count: got %0d want 4", count); end
      in_valid = 1'b1; in_pc = 32'h10; in_inst = 32'h17;
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      cycle();
      tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL full_blocked_count: got %0d want 4", count); end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_pc = 32'(4 * k);
         #1;
         tests_run++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== 32'h13 + 32'(k))
            begin tests_failed++; $display("FAIL drain_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, out_valid, out_pc, out_inst, exp_pc, 32'h13 + 32'(k)); end
         cycle();
      end
      out_ready = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin tests_failed++; $display("FAIL drained_empty: count %0d v %b pc %h want 0 0 0", count, out_valid, out_pc); end
   endtask

   task automatic test_full_push_pop();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_pc = 32'h500 + 32'(4 * k); in_inst = 32'hA0 + 32'(k);
         cycle();
      end
      in_valid = 1'b1; in_pc = 32'h600; in_inst = 32'hBB; out_ready = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b0 || out_pc !== 32'h500) begin tests_failed++; $display("FAIL fullpp_pre: in_ready %b pc %h want 0 500", in_ready, out_pc); end
      cycle();
      tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL fullpp_count: got %0d want 3", count); end
      tests_run++; if (out_pc !== 32'h504) begin tests_failed++; $display("FAIL fullpp_head: got %h want 504", out_pc); end
      in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         #1;
         tests_run++; if (out_pc !== 32'h500 + 32'(4 * k)) begin tests_failed++; $display("FAIL fullpp_drain_%0d: got %h want %h", k, out_pc, 32'h500 + 32'(4 * k)); end
         cycle();
      end
      out_ready = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL fullpp_no_extra: count %0d v %b want 0 0", count, out_valid); end
   endtask

   task automatic test_back_to_back();
      // prime one entry, then push and pop every cycle
      in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'hC00; out_ready = 1'b0;
      cycle();
      for (int k = 1; k <= 10; k++) begin
         in_valid = 1'b1; in_pc = 32'h100 + 32'(4 * k); in_inst = 32'hC00 + 32'(k); out_ready = 1'b1;
         #1;
         tests_run++; if (count !== 3'd1 || out_pc !== 32'h100 + 32'(4 * (k - 1)) || out_inst !== 32'hC00 + 32'(k - 1))
            begin tests_failed++; $display("FAIL b2b_%0d: count %0d pc %h inst %h want 1 %h %h", k, count, out_pc, out_inst, 32'h100 + 32'(4 * (k - 1)), 32'hC00 + 32'(k - 1)); end
         cycle();
      end
      in_valid = 1'b0;
      #1;
      tests_run++; if (count !== 3'd1 || out_pc !== 32'h128) begin tests_failed++; $display("FAIL b2b_tail: count %0d pc %h want 1 128", count, out_pc); end
      cycle();
      out_ready = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL b2b_empty: got %0d want 0", count); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_pc = 32'h700 + 32'(4 * k); in_inst = 32'hD0; cycle();
      end
      tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_count: got %0d want 3", count); end
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'hE0;
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin tests_failed++; $display("FAIL flush_after: count %0d v %b pc %h want 0 0 0", count, out_valid, out_pc); end
      in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'hF0;
      cycle();
      in_valid = 1'b0;
      #1;
      tests_run++; if (count !== 3'd1 || out_pc !== 32'h300 || out_inst !== 32'hF0) begin tests_failed++; $display("FAIL flush_repush: count %0d pc %h inst %h want 1 300 f0", count, out_pc, out_inst); end
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL flush_final: got %0d want 0", count); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_pc = 32'h900 + 32'(4 * k); in_inst = 32'h9; cycle();
      end
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 32'h990;
      cycle();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_mid: count %0d v %b rdy %b want 0 0 1", count, out_valid, in_ready); end
   endtask

   task automatic test_bypass();
      in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h1234; out_ready = 1'b1;
      #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
      tests_run++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h1234) begin tests_failed++; $display("FAIL bypass_same_cycle: v %b pc %h inst %h want 1 40 1234", out_valid, out_pc, out_inst); end
      cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL bypass_count: count %0d v %b want 0 0", count, out_valid); end
`else
      tests_run++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin tests_failed++; $display("FAIL nobypass_same_cycle: v %b pc %h want 0 0", out_valid, out_pc); end
      cycle();
      in_valid = 1'b0;
      #1;
      tests_run++; if (count !== 3'd1 || out_pc !== 32'h40 || out_inst !== 32'h1234) begin tests_failed++; $display("FAIL nobypass_next: count %0d pc %h inst %h want 1 40 1234", count, out_pc, out_inst); end
      cycle();
      out_ready = 1'b0;
      #1;
      tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL nobypass_drain: got %0d want 0", count); end
`endif
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_fill_drain();
      test_full_push_pop();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_bypass();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
